muldiv_ctrl: RTL

//   Sequences the shared multiplier and iterative divider for the EX stage and owns the HI/LO registers.

---
 rtl/muldiv_ctrl_if.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between muldiv_ctrl and the shared mul/div unit.
// master: controller side (drives operands/start/annul); slave: unit side.
//   mul_signed/mul_ina/mul_inb -> multiplier, mul_result <- {hi,lo}
//   div_start/div_signed/div_opdata1/div_opdata2/div_annul -> divider
//   div_result <- {remainder,quotient}, div_ready <- 1-cycle valid
interface muldiv_ctrl_if;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    modport master (
        output mul_signed,
        output mul_ina,
        output mul_inb,
        input  mul_result,
        output div_start,
        output div_signed,
        output div_opdata1,
        output div_opdata2,
        output div_annul,
        input  div_result,
        input  div_ready
    );

    modport slave (
        input  mul_signed,
        input  mul_ina,
        input  mul_inb,
        output mul_result,
        input  div_start,
        input  div_signed,
        input  div_opdata1,
        input  div_opdata2,
        input  div_annul,
        output div_result,
        output div_ready
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// EX-stage mul/div sequencer that owns HI/LO and serves MFHI/MFLO reads.
// Ports: clk, rst (sync, active-high), flush, ex_hold, op_valid, op[2:0],
//   src_a/src_b[31:0] from EX; stallreq, busy, hi_rdata/lo_rdata out;
//   mdu (muldiv_ctrl_if.master) to the shared multiplier/divider.
module muldiv_ctrl #(
    parameter int MUL_LAT     = 2,
    parameter bit DIV0_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                ex_hold,
    input  logic                op_valid,
    input  logic [2:0]          op,
    input  logic [31:0]         src_a,
    input  logic [31:0]         src_b,
    output logic                stallreq,
    output logic                busy,
    output logic [31:0]         hi_rdata,
    output logic [31:0]         lo_rdata,
    muldiv_ctrl_if.master       mdu
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   mul_cnt;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;

    logic            is_mul;
    logic            is_div;
    logic            idle_op;
    logic            div0;
    logic            mul_done;
    logic            hi_we;
    logic            lo_we;
    logic [31:0]     hi_wd;
    logic [31:0]     lo_wd;

    assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
    assign idle_op  = (state == IDLE) && op_valid;
    assign div0     = DIV0_BYPASS && (src_b == 32'd0);
    assign mul_done = (state == MUL_WAIT) && (mul_cnt == '0);

    // The accept cycle must stall combinationally so EX holds the op
    // while its operands are being captured.
    assign stallreq = (idle_op && (is_mul || is_div))
                   || (state == MUL_WAIT)
                   || (state == DIV_WAIT);
    assign busy     = (state != IDLE);

    // start follows the state register; a flush kills it in the same
    // cycle that the abort pulse goes out.
    assign mdu.div_start = (state == DIV_WAIT) && !flush;
    assign mdu.div_annul = (state == DIV_WAIT) && flush;

    // HI/LO write port; flush suppresses every write on its edge.
    always_comb begin
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_wd = src_a;
        lo_wd = src_a;
        if (!flush) begin
            if (idle_op) begin
                if (op == OP_MTHI) hi_we = 1'b1;
                if (op == OP_MTLO) lo_we = 1'b1;
                if (is_div && div0) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    lo_wd = 32'hFFFF_FFFF;
                end
            end else if (mul_done) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                {hi_wd, lo_wd} = mdu.mul_result;
            end else if ((state == DIV_WAIT) && mdu.div_ready) begin
                hi_we = 1'b1;
                lo_we = 1'b1;
                {hi_wd, lo_wd} = mdu.div_result;
            end
        end
    end

    // Same-cycle write is visible to MFHI/MFLO.
    assign hi_rdata = hi_we ? hi_wd : hi_q;
    assign lo_rdata = lo_we ? lo_wd : lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mul_cnt         <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            mdu.mul_signed  <= 1'b0;
            mdu.mul_ina     <= '0;
            mdu.mul_inb     <= '0;
            mdu.div_signed  <= 1'b0;
            mdu.div_opdata1 <= '0;
            mdu.div_opdata2 <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wd;
            if (lo_we) lo_q <= lo_wd;
            if (flush) begin
                state   <= IDLE;
                mul_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (op_valid && is_mul) begin
                            mdu.mul_signed <= (op == OP_MULT);
                            mdu.mul_ina    <= src_a;
                            mdu.mul_inb    <= src_b;
                            mul_cnt        <= CW'(MUL_LAT - 1);
                            state          <= MUL_WAIT;
                        end else if (op_valid && is_div) begin
                            if (div0) begin
                                state <= DONE;
                            end else begin
                                mdu.div_signed  <= (op == OP_DIV);
                                mdu.div_opdata1 <= src_a;
                                mdu.div_opdata2 <= src_b;
                                state           <= DIV_WAIT;
                            end
                        end
                    end
                    MUL_WAIT: begin
                        if (mul_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            mul_cnt <= mul_cnt - CW'(1);
                        end
                    end
                    DIV_WAIT: begin
                        if (mdu.div_ready) state <= DONE;
                    end
                    DONE: begin
                        // EX still holds the finished op; do not redo it.
                        if (!ex_hold) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
